// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its fetch buffer.
package ifetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } fetch_state_t;

  function automatic logic is_aligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry buffer of fetched {pc, instr} pairs; flush discards everything,
// push and pop may coincide when full. Head reads as zero when empty.
module fetch_fifo2
  import ifetch_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_data,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   count_q;

  // NOTE: sequential state is always updated with <= so every register
  // samples pre-edge values, independent of block ordering in simulation.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush) begin
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // NOTE: the storage array has no reset; validity is tracked by count_q,
  // so clearing the payload would only cost reset fan-out.
  always_ff @(posedge clk_i) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  // NOTE: head gets a default before any branch so no latch is inferred.
  always_comb begin
    head = '0;
    if (count_q != 2'd0) head = mem[rd_ptr];
  end

  assign count = count_q;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: sequential PC, combinational imem, 2-entry output buffer.
// Build option IFETCH_MISALIGN_TRAP_EN adds a misaligned-redirect trap state.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [XLEN-1:0] imem_instr_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_pc_o,
  output logic [XLEN-1:0] out_instr_o
`ifdef IFETCH_MISALIGN_TRAP_EN
  ,
  output logic            misalign_o
`endif
);

  localparam logic [1:0]      FULL_COUNT = 2'(FIFO_DEPTH);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INSTR_BYTES);

  logic [XLEN-1:0] fetch_pc;
  fetch_state_t    state;
  logic [1:0]      count;
  fetch_entry_t    head;
  fetch_entry_t    push_data;
  logic            running;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] redirect_target;

`ifdef IFETCH_MISALIGN_TRAP_EN
  assign redirect_target = redirect_pc_i;
`else
  // Without the trap, low address bits of a redirect are simply dropped.
  assign redirect_target = redirect_pc_i & ~XLEN'(INSTR_BYTES - 1);
`endif

  assign running   = (state == RUN);
  assign pop       = out_valid_o & out_ready_i;
  assign push      = running & ((count < FULL_COUNT) | pop) & ~redirect_valid_i;
  assign push_data = '{pc: fetch_pc, instr: imem_instr_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc   <= RESET_PC;
      state      <= RUN;
`ifdef IFETCH_MISALIGN_TRAP_EN
      misalign_o <= 1'b0;
`endif
    end else if (redirect_valid_i) begin
      fetch_pc <= redirect_target;
`ifdef IFETCH_MISALIGN_TRAP_EN
      if (is_aligned(redirect_pc_i)) begin
        state      <= RUN;
        misalign_o <= 1'b0;
      end else begin
        state      <= TRAP;
        misalign_o <= 1'b1;
      end
`endif
    end else if (push) begin
      fetch_pc <= fetch_pc + PC_STEP;
    end
  end

  // A redirect flushes the buffer, so a pop in the same cycle is simply lost.
  fetch_fifo2 u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_valid_i),
    .push_data (push_data),
    .count     (count),
    .head      (head)
  );

  assign imem_addr_o = fetch_pc;
  assign out_valid_o = running & (count != 2'd0);
  assign out_pc_o    = head.pc;
  assign out_instr_o = head.instr;

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: queue-level reference model compared every
// cycle, directed literal scenarios, then randomized redirect/ready/reset traffic.
module tb_ifetch;
  import ifetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ready;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  logic [31:0] w_addr;
  logic [31:0] w_instr;
  logic        w_valid;
  logic [31:0] w_pc;
  logic [31:0] w_out_instr;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h00A0_2093;
      32'h4:   return 32'h0140_2113;
      32'h8:   return 32'h0020_81B3;
      32'hC:   return 32'h0000_0013;
      default: return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endcase
  endfunction

  assign imem_instr = mem_word(imem_addr);
  assign w_instr    = mem_word(w_addr);

  ifetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .imem_addr_o      (imem_addr),
    .imem_instr_i     (imem_instr),
    .out_valid_o      (out_valid),
    .out_ready_i      (ready),
    .out_pc_o         (out_pc),
    .out_instr_o      (out_instr)
`ifdef IFETCH_MISALIGN_TRAP_EN
    ,
    .misalign_o       (misalign)
`endif
  );

  // Free-running instance for the address wrap scenario.
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic w_misalign;
`endif
  ifetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) u_wrap (
    .clk_i            (clk),
    .rst_i            (rst),
    .redirect_valid_i (1'b0),
    .redirect_pc_i    (32'h0),
    .imem_addr_o      (w_addr),
    .imem_instr_i     (w_instr),
    .out_valid_o      (w_valid),
    .out_ready_i      (1'b1),
    .out_pc_o         (w_pc),
    .out_instr_o      (w_out_instr)
`ifdef IFETCH_MISALIGN_TRAP_EN
    ,
    .misalign_o       (w_misalign)
`endif
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of at most two fetched entries plus the next fetch address.
  fetch_entry_t mq[$];
  logic [31:0]  m_pc;
  bit           m_trap;
  bit           m_valid;
  bit           m_pop;
  bit           m_push;
  fetch_entry_t m_ent;
`ifdef IFETCH_MISALIGN_TRAP_EN
  bit           m_mis;
`endif

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_pc   = 32'h0;
      m_trap = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      m_mis  = 1'b0;
`endif
    end else begin
      m_valid = (mq.size() != 0) && !m_trap;
      m_pop   = m_valid && ready;
      m_push  = !m_trap && (mq.size() < 2 || m_pop) && !redirect_valid;
      if (redirect_valid) begin
        mq.delete();
`ifdef IFETCH_MISALIGN_TRAP_EN
        m_pc   = redirect_pc;
        m_trap = (redirect_pc % 4) != 0;
        m_mis  = m_trap;
`else
        m_pc   = redirect_pc - (redirect_pc % 4);
`endif
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (m_push) begin
          m_ent.pc    = m_pc;
          m_ent.instr = mem_word(m_pc);
          mq.push_back(m_ent);
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  fetch_entry_t exp_head;
  bit           exp_valid;

  always @(negedge clk) begin
    if (chk_en) begin
      exp_valid = (mq.size() != 0) && !m_trap;
      exp_head  = (mq.size() != 0) ? mq[0] : '0;
      check("m_valid", 32'(out_valid), 32'(exp_valid));
      check("m_pc", out_pc, exp_head.pc);
      check("m_instr", out_instr, exp_head.instr);
      check("m_addr", imem_addr, m_pc);
`ifdef IFETCH_MISALIGN_TRAP_EN
      check("m_misalign", 32'(misalign), 32'(m_mis));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [31:0] pc, input logic [31:0] instr);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_pc"}, out_pc, pc);
    check({name, "_instr"}, out_instr, instr);
  endtask

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    ready          = 1'b1;
    repeat (2) step();

    // Reset state, then the in-order stream and the wrapping instance.
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_instr", out_instr, 32'h0);
    check("wrap_rst_valid", 32'(w_valid), 32'd0);
`ifdef IFETCH_MISALIGN_TRAP_EN
    check("rst_misalign", 32'(misalign), 32'd0);
`endif
    rst    = 1'b0;
    chk_en = 1'b1;
    step();
    expect_out("seq0", 32'h0, 32'h00A0_2093);
    check("wrap0", w_pc, 32'hFFFF_FFF8);
    step();
    expect_out("seq1", 32'h4, 32'h0140_2113);
    check("wrap1", w_pc, 32'hFFFF_FFFC);
    step();
    expect_out("seq2", 32'h8, 32'h0020_81B3);
    check("wrap2", w_pc, 32'h0000_0000);
    check("wrap2_valid", 32'(w_valid), 32'd1);
    step();
    expect_out("seq3", 32'hC, 32'h0000_0013);

    // Backpressure: buffer fills, head holds, stream resumes without gaps.
    rst = 1'b1;
    step();
    rst   = 1'b0;
    ready = 1'b0;
    repeat (5) step();
    expect_out("stall_head", 32'h0, 32'h00A0_2093);
    check("stall_addr", imem_addr, 32'h8);
    ready = 1'b1;
    step();
    expect_out("resume0", 32'h4, 32'h0140_2113);
    step();
    expect_out("resume1", 32'h8, 32'h0020_81B3);
    step();
    expect_out("resume2", 32'hC, 32'h0000_0013);

    // Redirect while full with a simultaneous pop.
    rst = 1'b1;
    step();
    rst   = 1'b0;
    ready = 1'b0;
    repeat (3) step();
    ready          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8;
    step();
    redirect_valid = 1'b0;
    check("redir_valid", 32'(out_valid), 32'd0);
    check("redir_addr", imem_addr, 32'h8);
    step();
    expect_out("redir0", 32'h8, 32'h0020_81B3);
    step();
    expect_out("redir1", 32'hC, 32'h0000_0013);

    // Misaligned redirect.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h6;
    step();
    redirect_valid = 1'b0;
    check("mis_valid", 32'(out_valid), 32'd0);
`ifdef IFETCH_MISALIGN_TRAP_EN
    check("mis_flag", 32'(misalign), 32'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      check("trap_flag", 32'(misalign), 32'd1);
      check("trap_valid", 32'(out_valid), 32'd0);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h4;
    step();
    redirect_valid = 1'b0;
    check("untrap_flag", 32'(misalign), 32'd0);
`endif
    step();
    expect_out("mis_out", 32'h4, 32'h0140_2113);

    // Reset overrides a concurrent redirect.
    repeat (3) step();
    rst            = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    check("rstredir_addr", imem_addr, 32'h0);
    check("rstredir_valid", 32'(out_valid), 32'd0);
    step();
    expect_out("rstredir_out", 32'h0, 32'h00A0_2093);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      ready          = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       redirect_pc = 32'($urandom_range(0, 15)) * 32'd4;
        1:       redirect_pc = 32'($urandom_range(0, 63));
        2:       redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: redirect_pc = $urandom;
      endcase
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst            = 1'b0;
    redirect_valid = 1'b0;
    step();
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
